// File: rtl/note_sequencer_if.sv
// Recording-memory read port: request/acknowledge handshake between the
// playback sequencer (master) and the recording store (slave).
interface note_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [5:0]        mem_data;

    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/note_sequencer.sv
// Playback scheduler and voice arbiter for the single amplifier voice.
// Optional feature: NOTE_SEQUENCER_PREEMPT_EN lets a live key abort playback.
module note_sequencer #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              live_valid,
    input  logic [5:0]        live_code,
    input  logic              pb_start,
    input  logic              pb_stop,
    input  logic [ADDR_W-1:0] rec_len,
    note_sequencer_if.master  mem,
    output logic [2:0]        voice_octave,
    output logic [2:0]        voice_note,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, len_q;
    logic [31:0]       tick;
    logic              stop_pend;
    logic [5:0]        voice;
    logic              preempt, abort, start_ok, last_tick, last_entry;
    logic [5:0]        abort_voice;

`ifdef NOTE_SEQUENCER_PREEMPT_EN
    logic [5:0] pend_voice;
    assign preempt     = live_valid && (live_code[2:0] != 3'd0);
    // A live key wins over a plain stop; a bare pending stop keeps what was latched.
    assign abort_voice = preempt ? live_code : (pb_stop ? 6'd0 : pend_voice);
`else
    assign preempt     = 1'b0;
    assign abort_voice = 6'd0;
`endif

    assign abort      = pb_stop | preempt;
    assign start_ok   = pb_start & ~pb_stop;
    assign last_tick  = (tick == TICK_DIV - 32'd1);
    assign last_entry = (ADDR_W'(idx + 1'b1) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && rec_len != '0) state_nxt = FETCH;
            FETCH:   if (mem.mem_ack) state_nxt = (stop_pend | abort) ? IDLE : PLAY;
            PLAY:    if (abort) state_nxt = IDLE;
                     else if (last_tick) state_nxt = last_entry ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req  = (state == FETCH);
        mem.mem_addr = idx;
        busy         = (state != IDLE);
        voice_octave = voice[5:3];
        voice_note   = voice[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            len_q      <= '0;
            tick       <= '0;
            stop_pend  <= 1'b0;
            voice      <= '0;
            done       <= 1'b0;
`ifdef NOTE_SEQUENCER_PREEMPT_EN
            pend_voice <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q <= rec_len;
                        idx   <= '0;
                        voice <= '0;
                        done  <= (rec_len == '0);
                    end else if (live_valid) begin
                        voice <= live_code;
                    end
                end
                FETCH: begin
                    // Address stays put until the ack even when aborting.
                    if (mem.mem_ack) begin
                        stop_pend <= 1'b0;
                        if (stop_pend | abort) begin
                            voice <= abort_voice;
                        end else begin
                            voice <= mem.mem_data;
                            tick  <= '0;
                        end
                    end else if (abort) begin
                        stop_pend  <= 1'b1;
`ifdef NOTE_SEQUENCER_PREEMPT_EN
                        pend_voice <= abort_voice;
`endif
                    end
                end
                PLAY: begin
                    tick <= tick + 32'd1;
                    if (abort) begin
                        voice <= abort_voice;
                    end else if (last_tick) begin
                        if (last_entry) begin
                            voice <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback scheduler and voice arbiter for the piano's single amplifier voice. It shares the amplifier between live key events and the playback stream. During playback it walks the recording memory over a read request/acknowledge handshake and holds each recorded {octave, note} for a fixed note period. It sits between the debounced input/recording logic and the amplifier, and drives the amplifier's octave and note inputs.

## Interface
- TICK_DIV, 25000000, note period in clk cycles (must be ≥ 2)
- ADDR_W, 8, recording memory address width
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- live_valid  in  1  one-cycle pulse: live_code is valid
- live_code  in  6  {octave[5:3], note[2:0]}; note 0 means silence
- pb_start  in  1  one-cycle pulse: start playback from address 0
- pb_stop  in  1  one-cycle pulse: abort playback
- rec_len  in  ADDR_W  number of recorded entries; sampled only on an accepted pb_start
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address; stable while mem_req=1
- mem_ack  in  1  read acknowledge; mem_data is valid in the same cycle
- mem_data  in  6  {octave, note} entry
- voice_octave  out  3  to amplifier octave input
- voice_note  out  3  to amplifier note input; 0 means silent
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse when playback completes normally

## Operation
- States: IDLE, FETCH, PLAY.
- Registers: idx (ADDR_W), len_q (ADDR_W), tick (32 bit), stop_pend (1).
- IDLE behaviour:
  - live_valid loads voice_octave and voice_note from live_code on the next edge.
  - The voice holds until the next live_valid.
- IDLE with pb_start (accepted):
  - Loads len_q=rec_len and idx=0, and sets voice to 0.
  - If rec_len=0: pulses done the next cycle and stays IDLE, with no memory access.
  - Otherwise enters FETCH.
- FETCH: mem_req=1 and mem_addr=idx. On mem_ack, mem_data is loaded to the voice, tick is cleared, and the state moves to PLAY.
- PLAY behaviour:
  - tick increments every cycle.
  - When tick=TICK_DIV-1 and idx+1==len_q: voice is set to 0, done pulses, and the state moves to IDLE.
  - When tick=TICK_DIV-1 otherwise: idx increments and the state moves to FETCH.
- busy=1 in FETCH and PLAY.
- Handshake rules:
  - mem_req must not drop before mem_ack, and mem_addr must not change while mem_req=1.
  - mem_ack seen while mem_req=0 is ignored.
- pb_stop behaviour:
  - In PLAY: voice is set to 0 and the state moves to IDLE next edge, with no done pulse.
  - In FETCH: sets stop_pend. On the mem_ack, data is discarded, voice is set to 0, and the state moves to IDLE with no done pulse.
- Simultaneous and ignored events:
  - pb_start while busy is ignored.
  - pb_start and pb_stop in the same IDLE cycle: stop wins and the start is ignored.
  - live_valid while busy is ignored (see Configuration).
- Address wrap: idx is ADDR_W bits. The maximum sequence length is 2^ADDR_W-1 entries, and idx never wraps in normal operation.

## Timing
- Reset (async assert, sync release): state=IDLE, mem_req=0, mem_addr=0, voice_octave=0, voice_note=0, busy=0, done=0, tick=0, stop_pend=0.
- pb_start at edge N: busy=1 and mem_req=1 after edge N+1.
- mem_ack at edge M: the voice shows the new entry and mem_req=0 after edge M+1.
- Each entry occupies exactly TICK_DIV cycles in PLAY plus the fetch latency.
- With zero-wait memory (ack in the first req cycle), each note period is TICK_DIV+1 cycles.
- live_valid to voice update: 1 cycle.
- done is high for exactly one cycle, coincident with the first cycle of busy=0.

## Configuration
- NOTE_SEQUENCER_PREEMPT_EN defined:
  - live_valid with a nonzero note while busy aborts playback with the same rules as pb_stop. In FETCH it waits for mem_ack.
  - The live code is then loaded to the voice on entry to IDLE, and done is not pulsed.
  - live_valid with note 0 while busy is still ignored.
- NOTE_SEQUENCER_PREEMPT_EN undefined: all live_valid while busy is ignored.

## Test plan
- Reset mid-PLAY with voice=6'o43: assert rst_n=0 → all outputs 0 immediately; after release, state IDLE, and live_valid with 6'o52 gives voice 5/2 one cycle later.
- TICK_DIV=4, rec_len=3, memory {6'o41, 6'o53, 6'o67}, zero-wait ack → mem_addr 0, 1, 2 each held one cycle; each voice value held 5 cycles; done pulses once; busy falls with done; final voice 0.
- rec_len=0 with pb_start → done pulses 1 cycle later, mem_req never asserted, busy stays 0.
- Ack delayed 3 cycles, pb_stop in the first FETCH cycle → mem_req held until ack, addr stable at 0, data discarded, voice stays 0, no done.
- Preemption: live_valid 6'o31 during PLAY → with NOTE_SEQUENCER_PREEMPT_EN, busy falls and voice=3/1, no done; without it, playback continues unchanged to done.
- Simultaneous pb_start and pb_stop in IDLE → no request, busy stays 0; a later pb_start while busy is ignored, shown by mem_addr sequence continuity.
